// File: rtl/elastic_pkg.sv
// Helpers shared by the elastic plumbing blocks.
package elastic_pkg;

  localparam int ELASTIC_MAX_W = 256;

  // Left shift on a wide carrier; callers truncate the result to their width.
  function automatic logic [ELASTIC_MAX_W-1:0] elastic_shl(
    input logic [ELASTIC_MAX_W-1:0] data,
    input int                       shift
  );
    return data << shift;
  endfunction

endpackage

// File: rtl/elastic_fifo_ch.sv
// One channel: DEPTH-entry FIFO storing shifted payloads, or a pure wire path when BYPASS=1.
import elastic_pkg::*;

module elastic_fifo_ch #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 4,
  parameter int SHIFT  = 2,
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic              flush,
  input  logic [DATA_W-1:0] t_data,
  input  logic              t_valid,
  output logic              t_ready,
  output logic [DATA_W-1:0] i_data,
  output logic              i_valid,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("elastic_fifo_ch: DEPTH must be a power of 2 and at least 2");
  end
  if (SHIFT < 0 || SHIFT >= DATA_W || DATA_W > ELASTIC_MAX_W) begin : g_bad_shift
    $error("elastic_fifo_ch: SHIFT must be in 0..DATA_W-1 and DATA_W within ELASTIC_MAX_W");
  end

  logic [DATA_W-1:0] shl_data;
  assign shl_data = DATA_W'(elastic_shl(ELASTIC_MAX_W'(t_data), SHIFT));

  if (BYPASS) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, flush};

    assign i_data  = rstf ? shl_data : '0;
    assign i_valid = rstf & t_valid;
    assign t_ready = rstf & i_ready;
    assign level   = '0;
  end else begin : g_fifo
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              push;
    logic              pop;

    // Ready depends only on stored count and flush, never on i_ready.
    assign full    = (count == CNT_W'(DEPTH));
    assign t_ready = rstf & ~full & ~flush;
    assign i_valid = (count != '0);
    assign i_data  = i_valid ? mem[rd_ptr] : '0;
    assign level   = count;

    assign push = t_valid & t_ready;
    assign pop  = i_valid & i_ready & ~flush;

    always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= shl_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (!push && pop) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/elastic_fifo_array.sv
// NUM_CH independent elastic FIFO channels with per-channel payload shift and occupancy.
import elastic_pkg::*;

module elastic_fifo_array #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 33,
  parameter int DEPTH  = 4,
  parameter int SHIFT  = 2,
  parameter bit BYPASS = 1'b0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rstf,
  input  logic                     flush,
  input  logic [NUM_CH*DATA_W-1:0] t_data,
  input  logic [NUM_CH-1:0]        t_valid,
  output logic [NUM_CH-1:0]        t_ready,
  output logic [NUM_CH*DATA_W-1:0] i_data,
  output logic [NUM_CH-1:0]        i_valid,
  input  logic [NUM_CH-1:0]        i_ready,
  output logic [NUM_CH*CNT_W-1:0]  level
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    elastic_fifo_ch #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .SHIFT  (SHIFT),
      .BYPASS (BYPASS),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rstf    (rstf),
      .flush   (flush),
      .t_data  (t_data[c*DATA_W +: DATA_W]),
      .t_valid (t_valid[c]),
      .t_ready (t_ready[c]),
      .i_data  (i_data[c*DATA_W +: DATA_W]),
      .i_valid (i_valid[c]),
      .i_ready (i_ready[c]),
      .level   (level[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_elastic_fifo_array.sv
// Directed bench for elastic_fifo_array: FIFO build plus a BYPASS=1 build side by side.
module tb_elastic_fifo_array;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 33;
  localparam int CNT_W  = 3;

  logic                     clk = 1'b0;
  logic                     rstf = 1'b0;
  logic                     flush = 1'b0;
  logic [NUM_CH*DATA_W-1:0] t_data = '0;
  logic [NUM_CH-1:0]        t_valid = '0;
  logic [NUM_CH-1:0]        t_ready;
  logic [NUM_CH*DATA_W-1:0] i_data;
  logic [NUM_CH-1:0]        i_valid;
  logic [NUM_CH-1:0]        i_ready = '0;
  logic [NUM_CH*CNT_W-1:0]  level;

  logic [NUM_CH*DATA_W-1:0] b_t_data = '0;
  logic [NUM_CH-1:0]        b_t_valid = '0;
  logic [NUM_CH-1:0]        b_t_ready;
  logic [NUM_CH*DATA_W-1:0] b_i_data;
  logic [NUM_CH-1:0]        b_i_valid;
  logic [NUM_CH-1:0]        b_i_ready = '0;
  logic [NUM_CH*CNT_W-1:0]  b_level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elastic_fifo_array #(.BYPASS(1'b0)) dut (
    .clk(clk), .rstf(rstf), .flush(flush),
    .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready), .level(level)
  );

  elastic_fifo_array #(.BYPASS(1'b1)) dut_byp (
    .clk(clk), .rstf(rstf), .flush(flush),
    .t_data(b_t_data), .t_valid(b_t_valid), .t_ready(b_t_ready),
    .i_data(b_i_data), .i_valid(b_i_valid), .i_ready(b_i_ready), .level(b_level)
  );

  typedef struct {
    int                ch;
    logic              fl;
    logic              tv;
    logic [DATA_W-1:0] td;
    logic              ir;
    logic              e_tr;
    logic              e_iv;
    logic [DATA_W-1:0] e_id;
    logic [CNT_W-1:0]  e_lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int ch, logic fl, logic tv, logic [DATA_W-1:0] td, logic ir,
                              logic e_tr, logic e_iv, logic [DATA_W-1:0] e_id, logic [CNT_W-1:0] e_lvl);
    vec_t v;
    v.ch = ch; v.fl = fl; v.tv = tv; v.td = td; v.ir = ir;
    v.e_tr = e_tr; v.e_iv = e_iv; v.e_id = e_id; v.e_lvl = e_lvl;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ch(input string tag, input int ch, input logic e_tr, input logic e_iv,
                          input logic [DATA_W-1:0] e_id, input logic [CNT_W-1:0] e_lvl);
    check({tag, " t_ready"}, 64'(t_ready[ch]), 64'(e_tr));
    check({tag, " i_valid"}, 64'(i_valid[ch]), 64'(e_iv));
    check({tag, " i_data"},  64'(i_data[ch*DATA_W +: DATA_W]), 64'(e_id));
    check({tag, " level"},   64'(level[ch*CNT_W +: CNT_W]), 64'(e_lvl));
  endtask

  initial begin
    // Fill ch0 with 1..4, full blocks a fifth push.
    vecs.push_back(mk(0, 0, 1, 33'd1, 0,   1, 0, 33'd0, 3'd0));
    vecs.push_back(mk(0, 0, 1, 33'd2, 0,   1, 1, 33'd4, 3'd1));
    vecs.push_back(mk(0, 0, 1, 33'd3, 0,   1, 1, 33'd4, 3'd2));
    vecs.push_back(mk(0, 0, 1, 33'd4, 0,   1, 1, 33'd4, 3'd3));
    vecs.push_back(mk(0, 0, 1, 33'd5, 0,   0, 1, 33'd4, 3'd4));
    // Drain in order.
    vecs.push_back(mk(0, 0, 0, 33'd0, 1,   0, 1, 33'd4,  3'd4));
    vecs.push_back(mk(0, 0, 0, 33'd0, 1,   1, 1, 33'd8,  3'd3));
    vecs.push_back(mk(0, 0, 0, 33'd0, 1,   1, 1, 33'd12, 3'd2));
    vecs.push_back(mk(0, 0, 0, 33'd0, 1,   1, 1, 33'd16, 3'd1));
    vecs.push_back(mk(0, 0, 0, 33'd0, 1,   1, 0, 33'd0,  3'd0));
    // Refill across the pointer wrap; push while full with pop is refused.
    vecs.push_back(mk(0, 0, 1, 33'd10, 0,  1, 0, 33'd0,  3'd0));
    vecs.push_back(mk(0, 0, 1, 33'd11, 0,  1, 1, 33'd40, 3'd1));
    vecs.push_back(mk(0, 0, 1, 33'd12, 0,  1, 1, 33'd40, 3'd2));
    vecs.push_back(mk(0, 0, 1, 33'd13, 0,  1, 1, 33'd40, 3'd3));
    vecs.push_back(mk(0, 0, 1, 33'd99, 1,  0, 1, 33'd40, 3'd4));
    vecs.push_back(mk(0, 0, 0, 33'd0,  0,  1, 1, 33'd44, 3'd3));
    // Flush with 3 entries held, push and pop both presented.
    vecs.push_back(mk(0, 1, 1, 33'd7, 1,   0, 1, 33'd44, 3'd3));
    vecs.push_back(mk(0, 0, 0, 33'd0, 0,   1, 0, 33'd0,  3'd0));
    vecs.push_back(mk(0, 0, 1, 33'd8, 0,   1, 0, 33'd0,  3'd0));
    vecs.push_back(mk(0, 0, 0, 33'd0, 1,   1, 1, 33'd32, 3'd1));
    vecs.push_back(mk(0, 0, 0, 33'd0, 0,   1, 0, 33'd0,  3'd0));
    // Shift truncation on ch2.
    vecs.push_back(mk(2, 0, 1, 33'h1_FFFF_FFFF, 0, 1, 0, 33'd0,          3'd0));
    vecs.push_back(mk(2, 0, 0, 33'd0,           1, 1, 1, 33'h1_FFFF_FFFC, 3'd1));
    vecs.push_back(mk(2, 0, 0, 33'd0,           0, 1, 0, 33'd0,          3'd0));

    // Reset held 3 cycles; both builds drive all-zero outputs.
    b_t_valid = '1;
    b_i_ready = '1;
    b_t_data  = {33'd5, 33'd5, 33'd5};
    t_valid   = '1;
    i_ready   = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst t_ready", 64'(t_ready), 64'd0);
      check("rst i_valid", 64'(i_valid), 64'd0);
      check("rst level",   64'(level), 64'd0);
      check("rst i_data",  64'(|i_data), 64'd0);
      check("rst byp outputs", 64'({|b_i_data, b_i_valid, b_t_ready, b_level}), 64'd0);
    end
    next_cycle();
    t_valid = '0;
    i_ready = '0;
    rstf = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      t_valid = '0;
      i_ready = '0;
      t_data  = '0;
      flush   = v.fl;
      t_valid[v.ch] = v.tv;
      i_ready[v.ch] = v.ir;
      t_data[v.ch*DATA_W +: DATA_W] = v.td;
      @(negedge clk);
      check_ch($sformatf("vec%0d", i), v.ch, v.e_tr, v.e_iv, v.e_id, v.e_lvl);
      next_cycle();
    end
    flush = 1'b0;
    t_valid = '0;
    i_ready = '0;

    // Streaming on ch1: one transfer per cycle after the first.
    for (int k = 0; k < 10; k++) begin
      t_valid[1] = 1'b1;
      i_ready[1] = 1'b1;
      t_data[DATA_W +: DATA_W] = DATA_W'(100 + k);
      @(negedge clk);
      if (k == 0) check_ch("stream first", 1, 1'b1, 1'b0, 33'd0, 3'd0);
      else        check_ch($sformatf("stream%0d", k), 1, 1'b1, 1'b1, DATA_W'((100 + k - 1) * 4), 3'd1);
      next_cycle();
    end
    t_valid[1] = 1'b0;
    @(negedge clk);
    check_ch("stream tail", 1, 1'b1, 1'b1, 33'd436, 3'd1);
    next_cycle();
    i_ready[1] = 1'b0;
    @(negedge clk);
    check_ch("stream empty", 1, 1'b1, 1'b0, 33'd0, 3'd0);
    next_cycle();

    // Reset mid-operation drops contents and ready without a clock edge.
    t_valid[0] = 1'b1;
    t_data[0 +: DATA_W] = 33'd9;
    next_cycle();
    t_valid[0] = 1'b0;
    #2;
    rstf = 1'b0;
    #1;
    check("async rst t_ready", 64'(t_ready), 64'd0);
    check("async rst i_valid", 64'(i_valid), 64'd0);
    check("async rst level",   64'(level), 64'd0);
    check("async rst i_data",  64'(|i_data), 64'd0);
    next_cycle();
    rstf = 1'b1;
    @(negedge clk);
    check("post rst t_ready", 64'(t_ready), 64'h7);
    next_cycle();

    // Bypass build: same-cycle pass-through, ready follows i_ready.
    for (int k = 0; k < 4; k++) begin
      b_i_ready = (k % 2 == 1) ? 3'b111 : 3'b000;
      flush = (k == 2);
      #1;
      check($sformatf("byp%0d t_ready", k), 64'(b_t_ready), (k % 2 == 1) ? 64'h7 : 64'h0);
      check($sformatf("byp%0d i_valid", k), 64'(b_i_valid), 64'h7);
      check($sformatf("byp%0d i_data0", k), 64'(b_i_data[0 +: DATA_W]), 64'd20);
      check($sformatf("byp%0d i_data2", k), 64'(b_i_data[2*DATA_W +: DATA_W]), 64'd20);
      check($sformatf("byp%0d level", k), 64'(b_level), 64'd0);
      next_cycle();
    end
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elastic_fifo_array.md
Name: elastic_fifo_array

Overview:
- NUM_CH independent valid/ready channels. Each channel has a DEPTH-entry elastic FIFO and applies a fixed left shift to its payload.
- Next-generation elastic stage for datapath plumbing. Generalises the per-channel single-register stage in width, depth and channel count.
- Adds a fully registered ready path, a per-channel occupancy output, a flush, and a combinational bypass mode.
- Sits between producer and consumer stages to absorb backpressure bursts.

Parameters:
- NUM_CH, 3, number of independent channels.
- DATA_W, 33, payload width per channel in bits.
- DEPTH, 4, FIFO entries per channel; power of 2, minimum 2.
- SHIFT, 2, left-shift applied to the payload; 0 to DATA_W-1.
- BYPASS, 0, 1 selects the combinational pass-through mode (no storage).
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rstf  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous clear of all channels.
- t_data  in  NUM_CH*DATA_W  packed target payloads; channel c occupies [c*DATA_W +: DATA_W].
- t_valid  in  NUM_CH  per-channel target valid.
- t_ready  out  NUM_CH  per-channel target ready.
- i_data  out  NUM_CH*DATA_W  packed initiator payloads.
- i_valid  out  NUM_CH  per-channel initiator valid.
- i_ready  in  NUM_CH  per-channel initiator ready.
- level  out  NUM_CH*CNT_W  per-channel occupancy, packed.

Behaviour:
- Reset (rstf low, asynchronous): read/write pointers and counts go to 0; storage goes to 0. Outputs: i_valid=0, i_data=0, level=0, t_ready=0 while rstf is low.
- Push on channel c when t_valid[c] & t_ready[c] at a clk edge. Stored value = (t_data_c << SHIFT), truncated to DATA_W; the upper SHIFT bits are dropped and the low bits are zero-filled.
- Pop on channel c when i_valid[c] & i_ready[c] at a clk edge.
- t_ready[c] = rstf & ~full[c] & ~flush. It is a function of registered state and flush only, with no combinational path from i_ready.
- Full and push: when count=DEPTH, t_ready=0; a simultaneous pop does not enable a push that cycle.
- i_valid[c] = (count[c] != 0). i_data_c = entry at the read pointer when i_valid is high, else 0.
- Latency: a push at edge N makes the data visible on i_data/i_valid after edge N (one-cycle latency). It can be popped at edge N+1.
- Throughput: one push and one pop per channel per cycle simultaneously, whenever not full and not empty.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Pointers: log2(DEPTH) bits, wrapping naturally modulo DEPTH. count is CNT_W bits, range 0..DEPTH.
- Ordering: strict FIFO order per channel. Channels are fully independent, with no cross-channel stall.
- level_c = count[c], registered.
- flush (synchronous, all channels): at the edge, pointers and counts go to 0. A push or pop presented that cycle is discarded and not counted. Next cycle: i_valid=0, level=0.
- AXI-style rule: once asserted, i_valid stays high and i_data stays stable until the pop, except on flush or reset.
- Reset mid-operation: contents are lost immediately; t_ready falls asynchronously with rstf.
- BYPASS=1, per channel:
  - i_data = rstf ? (t_data << SHIFT) : 0.
  - i_valid = rstf & t_valid.
  - t_ready = rstf & i_ready.
  - level = 0.
  - flush is ignored.
  - No clocked state.
- Illegal parameters (DEPTH not a power of 2 or < 2, SHIFT >= DATA_W) fail elaboration via $error.

Decomposition:
- Shared package elastic_pkg: function clog2-based count width helper; localparam-free typedef for the occupancy struct is unnecessary. Keep only the shift/truncate function elastic_shl(data, shift) for reuse by other elastic blocks.
- Sub-module elastic_fifo_ch: one channel FIFO, holding storage, pointers, count, flush and the bypass generate branch.
- Top level: generate loop over NUM_CH instantiating elastic_fifo_ch, plus packing/unpacking of the buses.

Test Plan:
- Reset and fill: rstf low for 3 cycles, then high with i_ready=0; push 1,2,3,4 on ch0. Required: t_ready=0 during reset; after 4 pushes level0=4 and t_ready[0]=0; i_data0=4 (1<<2) with i_valid=1.
- Drain order: from the full state, i_ready=1 for 4 cycles. Required: i_data0 sequence 4,8,12,16; level0 3,2,1,0; i_valid falls after the 4th pop.
- Streaming: t_valid=1 and i_ready=1 continuously on ch1 with incrementing data. Required: one transfer per cycle after the first-cycle latency; level1 stays 1; no bubbles.
- Shift truncation: push 0x1_FFFF_FFFF on ch2 (DATA_W=33). Required: i_data2=0x1_FFFF_FFFC.
- Flush mid-traffic: ch0 holds 3 entries, flush pulsed while t_valid=1 and i_ready=1. Required: next cycle level0=0 and i_valid0=0; the pushed word never appears; t_ready low during the flush cycle.
- Bypass build (BYPASS=1): t_valid=1, t_data=5, i_ready toggling. Required: same-cycle i_data=20 and i_valid=1; t_ready tracks i_ready; all outputs 0 while rstf is low.
